// File: rtl/mux_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and constants for the 4-to-1 mux scan
//               sequencer: FSM state encoding and select-path sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    localparam int                SEL_W    = 2;
    localparam int                NUM_IN   = 4;
    localparam logic [SEL_W-1:0]  LAST_SEL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } scan_state_t;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/scan_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_settle_timer
// Description : Settle counter for the mux scan sequencer. Counts cycles
//               while enabled and flags the last settle cycle so the FSM
//               can move on to capture.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               i_clr  - synchronous clear to zero (wins over i_en)
//               i_en   - count enable
//               o_tc   - terminal count, high while count == SETTLE_CYC-1
// Revision    : 1.0 - initial release
// ============================================================================
module scan_settle_timer #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] c_TC_VAL = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc = (r_count == c_TC_VAL);

endmodule : scan_settle_timer
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Walks the 4-to-1 mux select pair {s1,s0} through 00..11,
//               waits SETTLE_CYC cycles at each select, captures the mux
//               output once per select and publishes the four bits as one
//               word with a single-cycle valid pulse.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               start      - scan request, only looked at in IDLE
//               mux_out    - mux output being sampled
//               s1, s0     - mux select MSB / LSB
//               busy       - scan in progress (SETTLE, CAPTURE, DONE)
//               sample     - last completed scan, bit i from select i
//               sample_vld - one-cycle pulse when sample is updated
//               sample_par - ^sample (only with SCAN_PARITY_EN defined)
// Build macro : SCAN_PARITY_EN - adds the registered sample_par output
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mux_out,
    output logic              s1,
    output logic              s0,
    output logic              busy,
    output logic [NUM_IN-1:0] sample,
    output logic              sample_vld
`ifdef SCAN_PARITY_EN
    ,
    output logic              sample_par
`endif
);

    scan_state_t        r_state;
    scan_state_t        w_next_state;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_IN-1:0]  r_shadow;
    logic [NUM_IN-1:0]  r_sample;
    logic               r_sample_vld;
    logic [NUM_IN-1:0]  w_final;
    logic               w_tc;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_last_sel;
`ifdef SCAN_PARITY_EN
    logic               r_sample_par;
`endif

    // The counter only runs in SETTLE; holding it clear everywhere else
    // gives every select a fresh count starting from zero.
    assign w_cnt_en  = (r_state == ST_SETTLE);
    assign w_cnt_clr = (r_state != ST_SETTLE);

    scan_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    assign w_last_sel = (r_sel == LAST_SEL);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next_state = ST_SETTLE;
            ST_SETTLE:  if (w_tc)  w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = w_last_sel ? ST_DONE : ST_SETTLE;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Select, shadow and published sample
    // ------------------------------------------------------------------
    // The word published on entry to DONE must already hold the bit being
    // captured on the same edge, so it is merged here straight from mux_out.
    always_comb begin
        w_final           = r_shadow;
        w_final[LAST_SEL] = mux_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_shadow     <= '0;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
`ifdef SCAN_PARITY_EN
            r_sample_par <= 1'b0;
`endif
        end else begin
            r_sample_vld <= 1'b0;
            case (r_state)
                ST_CAPTURE: begin
                    r_shadow[r_sel] <= mux_out;
                    if (w_last_sel) begin
                        // Valid is raised together with the data so the
                        // pulse occupies the DONE cycle.
                        r_sample     <= w_final;
                        r_sample_vld <= 1'b1;
`ifdef SCAN_PARITY_EN
                        r_sample_par <= ^w_final;
`endif
                    end else begin
                        r_sel <= r_sel + SEL_W'(1);
                    end
                end
                ST_DONE: begin
                    r_sel <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign s1         = r_sel[1];
    assign s0         = r_sel[0];
    assign busy       = (r_state != ST_IDLE);
    assign sample     = r_sample;
    assign sample_vld = r_sample_vld;
`ifdef SCAN_PARITY_EN
    assign sample_par = r_sample_par;
`endif

endmodule : mux_scan_sequencer
`default_nettype wire
